// File: rtl/mesi_pkg.sv
// MESI state and snoop command encodings plus the next-state rules shared by
// the cache controller, cache arrays and bus model.
package mesi_pkg;

   typedef enum logic [1:0] {
      MESI_I = 2'b00,
      MESI_S = 2'b01,
      MESI_E = 2'b10,
      MESI_M = 2'b11
   } mesi_t;

   typedef enum logic [1:0] {
      SNP_NONE   = 2'd0,
      SNP_BUSRD  = 2'd1,
      SNP_BUSRDX = 2'd2,
      SNP_INVAL  = 2'd3
   } snp_cmd_t;

   typedef struct packed {
      mesi_t nxt;
      logic  busrd;
      logic  busrdx;
      logic  inval;
   } proc_rsp_t;

   // Several command lines may be raised together; the strongest wins.
   function automatic snp_cmd_t snp_decode(input logic busrd, input logic busrdx,
                                           input logic inval);
      if (busrdx)     return SNP_BUSRDX;
      else if (inval) return SNP_INVAL;
      else if (busrd) return SNP_BUSRD;
      else            return SNP_NONE;
   endfunction

   function automatic proc_rsp_t proc_next(input logic hit, input logic wr,
                                           input mesi_t cur, input logic shared);
      proc_rsp_t r;
      r.nxt    = cur;
      r.busrd  = 1'b0;
      r.busrdx = 1'b0;
      r.inval  = 1'b0;
      if (!hit) begin
         if (wr) begin
            r.nxt    = MESI_M;
            r.busrdx = 1'b1;
         end else begin
            r.nxt    = shared ? MESI_S : MESI_E;
            r.busrd  = 1'b1;
         end
      end else if (wr) begin
         r.nxt = MESI_M;
         case (cur)
            MESI_S:         r.inval  = 1'b1;
            MESI_E, MESI_M: r.inval  = 1'b0;
            default:        r.busrdx = 1'b1;  // hit on an I line behaves as a write miss
         endcase
      end
      return r;
   endfunction

   function automatic mesi_t snp_next(input snp_cmd_t cmd, input mesi_t cur);
      case (cmd)
         SNP_BUSRDX, SNP_INVAL: return MESI_I;
         SNP_BUSRD:             return (cur == MESI_I) ? MESI_I : MESI_S;
         default:               return cur;
      endcase
   endfunction

endpackage

// File: rtl/plru_tree.sv
// Per-set tree pseudo-LRU: WAYS-1 bits per set, node n has children 2n+1/2n+2,
// a 0 bit points the victim walk into the left (lower-numbered) subtree.
module plru_tree #(
   parameter int WAYS  = 4,
   parameter int SETS  = 256,
   parameter int IDX_W = $clog2(SETS),
   parameter int WAY_W = $clog2(WAYS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] index,
   output logic [WAY_W-1:0] victim,
   input  logic             upd_en,
   input  logic [WAY_W-1:0] upd_way
);

   localparam int NODES = WAYS - 1;

   logic [NODES-1:0] tree_q [SETS];
   logic [NODES-1:0] cur_bits;
   logic [NODES-1:0] upd_bits;

   function automatic logic [WAY_W-1:0] walk(input logic [NODES-1:0] t);
      logic [WAY_W-1:0] w;
      logic             b;
      int               node;
      w    = '0;
      node = 0;
      for (int l = 0; l < WAY_W; l++) begin
         b = 1'b0;
         for (int n = 0; n < NODES; n++)
            if (n == node) b = t[n];
         w[WAY_W-1-l] = b;
         node = 2 * node + (b ? 2 : 1);
      end
      return w;
   endfunction

   // Every node on the path to the accessed way is turned to face away from it.
   function automatic logic [NODES-1:0] touch(input logic [NODES-1:0] t,
                                              input logic [WAY_W-1:0] way);
      logic [NODES-1:0] r;
      logic             d;
      int               node;
      r    = t;
      node = 0;
      for (int l = 0; l < WAY_W; l++) begin
         d = way[WAY_W-1-l];
         for (int n = 0; n < NODES; n++)
            if (n == node) r[n] = ~d;
         node = 2 * node + (d ? 2 : 1);
      end
      return r;
   endfunction

   assign cur_bits = tree_q[index];
   assign victim   = walk(cur_bits);
   assign upd_bits = touch(cur_bits, upd_way);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SETS; s++)
            tree_q[s] <= '0;
      end else if (upd_en) begin
         tree_q[index] <= upd_bits;
      end
   end

endmodule

// File: rtl/mesi_plru_ctrl.sv
// Per-core cache controller: PLRU victim choice and MESI next state for
// processor and snoop sides, one-cycle registered responses.
// Defining CC_SNOOP_FLUSH_EN adds the snp_flush dirty-data output.
module mesi_plru_ctrl
   import mesi_pkg::*;
#(
   parameter int WAYS  = 4,
   parameter int SETS  = 256,
   parameter int IDX_W = $clog2(SETS),
   parameter int WAY_W = $clog2(WAYS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             proc_valid,
   output logic             proc_ready,
   input  logic             proc_rd,
   input  logic             proc_wr,
   input  logic [IDX_W-1:0] proc_index,
   input  logic             proc_hit,
   input  logic [WAY_W-1:0] proc_hit_way,
   input  logic [1:0]       proc_mesi_cur,
   input  logic             shared,
   output logic             proc_done,
   output logic [WAY_W-1:0] proc_way,
   output logic [1:0]       proc_mesi_next,
   output logic             proc_busrd,
   output logic             proc_busrdx,
   output logic             proc_inval,
   input  logic             snp_valid,
   input  logic             snp_busrd,
   input  logic             snp_busrdx,
   input  logic             snp_inval,
   input  logic [IDX_W-1:0] snp_index,
   input  logic [1:0]       snp_mesi_cur,
   output logic             snp_done,
   output logic [1:0]       snp_mesi_next,
   output logic             snp_flush
);

   logic             collide;
   logic [WAY_W-1:0] victim;
   logic [WAY_W-1:0] way_sel;
   proc_rsp_t        rsp;
   snp_cmd_t         cmd;
   mesi_t            snp_nxt;
   logic             unused_rd;

   // proc_wr alone selects write; a request with proc_wr low is a read.
   assign unused_rd = proc_rd;

   // Snoop owns a contested set for this cycle; processor retries.
   assign collide    = snp_valid && (snp_index == proc_index);
   assign proc_ready = proc_valid && !collide;

   assign way_sel = proc_hit ? proc_hit_way : victim;
   assign rsp     = proc_next(proc_hit, proc_wr, mesi_t'(proc_mesi_cur), shared);
   assign cmd     = snp_decode(snp_busrd, snp_busrdx, snp_inval);
   assign snp_nxt = snp_next(cmd, mesi_t'(snp_mesi_cur));

   plru_tree #(
      .WAYS  (WAYS),
      .SETS  (SETS),
      .IDX_W (IDX_W),
      .WAY_W (WAY_W)
   ) u_plru (
      .clk     (clk),
      .rst     (rst),
      .index   (proc_index),
      .victim  (victim),
      .upd_en  (proc_ready),
      .upd_way (way_sel)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         proc_done      <= 1'b0;
         proc_way       <= '0;
         proc_mesi_next <= '0;
         proc_busrd     <= 1'b0;
         proc_busrdx    <= 1'b0;
         proc_inval     <= 1'b0;
      end else begin
         proc_done <= proc_ready;
         if (proc_ready) begin
            proc_way       <= way_sel;
            proc_mesi_next <= rsp.nxt;
            proc_busrd     <= rsp.busrd;
            proc_busrdx    <= rsp.busrdx;
            proc_inval     <= rsp.inval;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snp_done      <= 1'b0;
         snp_mesi_next <= '0;
      end else begin
         snp_done <= snp_valid;
         if (snp_valid)
            snp_mesi_next <= snp_nxt;
      end
   end

`ifdef CC_SNOOP_FLUSH_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         snp_flush <= 1'b0;
      else
         snp_flush <= snp_valid && (snp_mesi_cur == MESI_M) &&
                      (cmd == SNP_BUSRD || cmd == SNP_BUSRDX);
   end
`else
   assign snp_flush = 1'b0;
`endif

endmodule

// File: tb/tb_mesi_plru_ctrl.sv
// Randomised and directed bench for mesi_plru_ctrl against a behavioural model.
module tb_mesi_plru_ctrl;

   localparam int WAYS  = 8;
   localparam int SETS  = 16;
   localparam int IDX_W = 4;
   localparam int WAY_W = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             proc_valid, proc_rd, proc_wr, proc_hit, shared;
   logic [IDX_W-1:0] proc_index, snp_index;
   logic [WAY_W-1:0] proc_hit_way, proc_way;
   logic [1:0]       proc_mesi_cur, snp_mesi_cur, proc_mesi_next, snp_mesi_next;
   logic             proc_ready, proc_done, proc_busrd, proc_busrdx, proc_inval;
   logic             snp_valid, snp_busrd, snp_busrdx, snp_inval, snp_done, snp_flush;

   int checks = 0;
   int errors = 0;

   // model: tree bits per set, and the expected (held) outputs
   int               tree_m [SETS][WAYS-1];
   logic             e_ready, e_pdone, e_sdone, got_ready, e_flush;
   logic [WAY_W-1:0] e_way;
   logic [1:0]       e_pmesi, e_smesi;
   logic [2:0]       e_bus;

   mesi_plru_ctrl #(.WAYS(WAYS), .SETS(SETS)) dut (
      .clk(clk), .rst(rst),
      .proc_valid(proc_valid), .proc_ready(proc_ready), .proc_rd(proc_rd), .proc_wr(proc_wr),
      .proc_index(proc_index), .proc_hit(proc_hit), .proc_hit_way(proc_hit_way),
      .proc_mesi_cur(proc_mesi_cur), .shared(shared), .proc_done(proc_done),
      .proc_way(proc_way), .proc_mesi_next(proc_mesi_next), .proc_busrd(proc_busrd),
      .proc_busrdx(proc_busrdx), .proc_inval(proc_inval),
      .snp_valid(snp_valid), .snp_busrd(snp_busrd), .snp_busrdx(snp_busrdx),
      .snp_inval(snp_inval), .snp_index(snp_index), .snp_mesi_cur(snp_mesi_cur),
      .snp_done(snp_done), .snp_mesi_next(snp_mesi_next), .snp_flush(snp_flush)
   );

   always #5 clk = ~clk;

   function automatic int m_victim(int s);
      int n = 0;
      int w = 0;
      for (int l = 0; l < WAY_W; l++) begin
         w = 2 * w + tree_m[s][n];
         n = 2 * n + 1 + tree_m[s][n];
      end
      return w;
   endfunction

   function automatic void m_touch(int s, int w);
      int n = 0;
      int d;
      for (int l = WAY_W - 1; l >= 0; l--) begin
         d = (w >> l) & 1;
         tree_m[s][n] = 1 - d;
         n = 2 * n + 1 + d;
      end
   endfunction

   // {next state, busrd, busrdx, inval}
   function automatic logic [4:0] exp_proc(logic hit, logic wr, logic [1:0] cur, logic sh);
      if (!hit) return wr ? 5'b11_010 : (sh ? 5'b01_100 : 5'b10_100);
      if (wr)   return (cur == 2'b01) ? 5'b11_001 : 5'b11_000;
      return {cur, 3'b000};
   endfunction

   // {next state, flush}
   function automatic logic [2:0] exp_snp(logic rd, logic rdx, logic inv, logic [1:0] cur);
      logic [1:0] n;
      logic       f;
      if (rdx || inv) n = 2'b00;
      else if (rd)    n = (cur == 2'b00) ? 2'b00 : 2'b01;
      else            n = cur;
`ifdef CC_SNOOP_FLUSH_EN
      f = (cur == 2'b11) && (rdx || (rd && !inv));
`else
      f = 1'b0;
`endif
      return {n, f};
   endfunction

   task automatic idle();
      proc_valid = 0; proc_rd = 0; proc_wr = 0; proc_index = '0; proc_hit = 0;
      proc_hit_way = '0; proc_mesi_cur = '0; shared = 0;
      snp_valid = 0; snp_busrd = 0; snp_busrdx = 0; snp_inval = 0;
      snp_index = '0; snp_mesi_cur = '0;
   endtask

   task automatic clear_model();
      for (int s = 0; s < SETS; s++)
         for (int n = 0; n < WAYS - 1; n++) tree_m[s][n] = 0;
      e_way = '0; e_pmesi = '0; e_bus = '0; e_smesi = '0; e_flush = 0;
      e_pdone = 0; e_sdone = 0;
   endtask

   // Called at posedge+1 with inputs set; returns at the next posedge+1.
   task automatic tick();
      logic [4:0] pr;
      logic [2:0] sr;
      e_ready = proc_valid && !(snp_valid && snp_index == proc_index);
      #1 got_ready = proc_ready;
      if (e_ready) begin
         e_way = proc_hit ? proc_hit_way : WAY_W'(m_victim(int'(proc_index)));
         pr = exp_proc(proc_hit, proc_wr, proc_mesi_cur, shared);
         e_pmesi = pr[4:3];
         e_bus   = pr[2:0];
         m_touch(int'(proc_index), int'(e_way));
      end
      e_pdone = e_ready;
      if (snp_valid) begin
         sr = exp_snp(snp_busrd, snp_busrdx, snp_inval, snp_mesi_cur);
         e_smesi = sr[2:1];
         e_flush = sr[0];
      end else begin
         e_flush = 0;
      end
      e_sdone = snp_valid;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1;
      idle();
      clear_model();
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({proc_done, snp_done, proc_way, proc_mesi_next, proc_busrd, proc_busrdx,
           proc_inval, snp_mesi_next, snp_flush} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got done=%b/%b way=%0d pm=%0d bus=%b%b%b sm=%0d fl=%b want all 0",
                  proc_done, snp_done, proc_way, proc_mesi_next, proc_busrd, proc_busrdx,
                  proc_inval, snp_mesi_next, snp_flush);
      end
      checks++;
      if (proc_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready got %b want 0", proc_ready);
      end
   endtask

   task automatic test_miss_fill();
      int seq [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
      for (int i = 0; i < 8; i++) begin
         idle();
         proc_valid = 1; proc_rd = 1; proc_index = 4'd5;
         tick();
         checks++;
         if (got_ready !== 1'b1 || proc_done !== 1'b1) begin
            errors++; $display("FAIL fill_done[%0d] got rdy=%b done=%b want 1 1", i, got_ready, proc_done);
         end
         checks++;
         if (proc_way !== WAY_W'(seq[i]) || proc_way !== e_way) begin
            errors++; $display("FAIL fill_way[%0d] got %0d want %0d", i, proc_way, seq[i]);
         end
         checks++;
         if (proc_mesi_next !== 2'b10 || {proc_busrd, proc_busrdx, proc_inval} !== 3'b100) begin
            errors++; $display("FAIL fill_state[%0d] got mesi=%0d bus=%b%b%b want 2 100",
                               i, proc_mesi_next, proc_busrd, proc_busrdx, proc_inval);
         end
      end
      idle();
      tick();
      checks++;
      if (proc_done !== 1'b0 || proc_way !== 3'd7 || proc_mesi_next !== 2'b10) begin
         errors++; $display("FAIL fill_hold got done=%b way=%0d mesi=%0d want 0 7 2",
                            proc_done, proc_way, proc_mesi_next);
      end
   endtask

   task automatic test_hit_write();
      // {cur state, way, wr} -> expected {mesi, busrd, busrdx, inval}
      logic [1:0] cur [3] = '{2'b01, 2'b10, 2'b11};
      logic       wr  [3] = '{1'b1, 1'b1, 1'b0};
      logic [4:0] exp [3] = '{5'b11_001, 5'b11_000, 5'b11_000};
      for (int i = 0; i < 3; i++) begin
         idle();
         proc_valid = 1; proc_wr = wr[i]; proc_rd = !wr[i]; proc_index = 4'd3;
         proc_hit = 1; proc_hit_way = WAY_W'(2 + i); proc_mesi_cur = cur[i]; shared = 1;
         tick();
         checks++;
         if (proc_done !== 1'b1 || proc_way !== WAY_W'(2 + i)) begin
            errors++; $display("FAIL hit_way[%0d] got done=%b way=%0d want 1 %0d", i, proc_done, proc_way, 2 + i);
         end
         checks++;
         if ({proc_mesi_next, proc_busrd, proc_busrdx, proc_inval} !== exp[i]) begin
            errors++; $display("FAIL hit_state[%0d] got %b want %b", i,
                               {proc_mesi_next, proc_busrd, proc_busrdx, proc_inval}, exp[i]);
         end
      end
   endtask

   task automatic test_collision();
      idle();
      proc_valid = 1; proc_wr = 1; proc_index = 4'd9;
      snp_valid = 1; snp_busrd = 1; snp_index = 4'd9; snp_mesi_cur = 2'b11;
      tick();
      checks++;
      if (got_ready !== 1'b0) begin
         errors++; $display("FAIL collide_ready got %b want 0", got_ready);
      end
      checks++;
      if (snp_done !== 1'b1 || proc_done !== 1'b0 || snp_mesi_next !== 2'b01) begin
         errors++; $display("FAIL collide_resp got sdone=%b pdone=%b smesi=%0d want 1 0 1",
                            snp_done, proc_done, snp_mesi_next);
      end
      snp_valid = 0; snp_busrd = 0;
      tick();
      checks++;
      if (got_ready !== 1'b1 || proc_done !== 1'b1 || snp_done !== 1'b0 || proc_way !== e_way) begin
         errors++; $display("FAIL collide_retry got rdy=%b pdone=%b sdone=%b way=%0d want 1 1 0 %0d",
                            got_ready, proc_done, snp_done, proc_way, e_way);
      end
   endtask

   task automatic test_snoop_cmds();
      // {busrd, busrdx, inval, cur}
      logic [4:0] tbl [10] = '{5'b110_11, 5'b100_11, 5'b100_10, 5'b100_01, 5'b100_00,
                               5'b001_11, 5'b010_10, 5'b000_10, 5'b101_11, 5'b010_11};
      for (int i = 0; i < 10; i++) begin
         idle();
         snp_valid = 1; snp_index = IDX_W'($urandom_range(0, SETS - 1));
         {snp_busrd, snp_busrdx, snp_inval, snp_mesi_cur} = tbl[i];
         tick();
         checks++;
         if (snp_done !== 1'b1 || snp_mesi_next !== e_smesi) begin
            errors++; $display("FAIL snoop_state[%0d] got done=%b mesi=%0d want 1 %0d",
                               i, snp_done, snp_mesi_next, e_smesi);
         end
         checks++;
         if (snp_flush !== e_flush) begin
            errors++; $display("FAIL snoop_flush[%0d] got %b want %b", i, snp_flush, e_flush);
         end
         if (i == 0) begin
            checks++;
            if (snp_mesi_next !== 2'b00) begin
               errors++; $display("FAIL snoop_rd_rdx_m got %0d want 0", snp_mesi_next);
            end
         end
      end
      idle();
      tick();
      checks++;
      if (snp_done !== 1'b0 || snp_flush !== 1'b0 || snp_mesi_next !== e_smesi) begin
         errors++; $display("FAIL snoop_hold got done=%b fl=%b mesi=%0d want 0 0 %0d",
                            snp_done, snp_flush, snp_mesi_next, e_smesi);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 2; i++) begin
         idle();
         proc_valid = 1; proc_rd = 1; proc_index = 4'd7; proc_hit = 1;
         proc_hit_way = 3'd3; proc_mesi_cur = 2'b10;
         tick();
         checks++;
         if (proc_done !== 1'b1 || proc_way !== 3'd3 || proc_mesi_next !== 2'b10) begin
            errors++; $display("FAIL b2b_hit[%0d] got done=%b way=%0d mesi=%0d want 1 3 2",
                               i, proc_done, proc_way, proc_mesi_next);
         end
      end
      idle();
      proc_valid = 1; proc_wr = 1; proc_index = 4'd7;
      tick();
      checks++;
      if (proc_way === 3'd3 || proc_way !== e_way) begin
         errors++; $display("FAIL b2b_victim got %0d want %0d (not 3)", proc_way, e_way);
      end
      checks++;
      if (proc_mesi_next !== 2'b11 || {proc_busrd, proc_busrdx, proc_inval} !== 3'b010) begin
         errors++; $display("FAIL b2b_wmiss got mesi=%0d bus=%b%b%b want 3 010",
                            proc_mesi_next, proc_busrd, proc_busrdx, proc_inval);
      end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int i = 0; i < 400; i++) begin
         proc_valid    = ($urandom_range(0, 3) != 0);
         proc_wr       = $urandom_range(0, 1);
         proc_rd       = !proc_wr || ($urandom_range(0, 1) == 1);
         proc_index    = IDX_W'($urandom_range(0, 3));
         proc_hit      = $urandom_range(0, 1);
         proc_hit_way  = WAY_W'($urandom_range(0, WAYS - 1));
         proc_mesi_cur = proc_hit ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
         shared        = $urandom_range(0, 1);
         snp_valid     = ($urandom_range(0, 2) == 0);
         {snp_busrd, snp_busrdx, snp_inval} = 3'($urandom_range(0, 7));
         snp_index     = IDX_W'($urandom_range(0, 3));
         snp_mesi_cur  = 2'($urandom_range(0, 3));
         tick();
         checks++;
         if (got_ready !== e_ready || proc_done !== e_pdone || snp_done !== e_sdone) begin
            errors++; bad++;
            if (bad < 10)
               $display("FAIL rand_handshake[%0d] got rdy=%b pd=%b sd=%b want %b %b %b",
                        i, got_ready, proc_done, snp_done, e_ready, e_pdone, e_sdone);
         end
         checks++;
         if (proc_way !== e_way || proc_mesi_next !== e_pmesi ||
             {proc_busrd, proc_busrdx, proc_inval} !== e_bus) begin
            errors++; bad++;
            if (bad < 10)
               $display("FAIL rand_proc[%0d] got way=%0d mesi=%0d bus=%b want %0d %0d %b", i,
                        proc_way, proc_mesi_next, {proc_busrd, proc_busrdx, proc_inval},
                        e_way, e_pmesi, e_bus);
         end
         checks++;
         if (snp_mesi_next !== e_smesi || snp_flush !== e_flush) begin
            errors++; bad++;
            if (bad < 10)
               $display("FAIL rand_snoop[%0d] got mesi=%0d fl=%b want %0d %b",
                        i, snp_mesi_next, snp_flush, e_smesi, e_flush);
         end
      end
   endtask

   task automatic test_reset_mid();
      idle();
      proc_valid = 1; proc_wr = 1; proc_index = 4'd2;
      snp_valid = 1; snp_busrdx = 1; snp_index = 4'd4; snp_mesi_cur = 2'b11;
      tick();
      rst = 1;
      #1;
      checks++;
      if (proc_done !== 1'b0 || snp_done !== 1'b0 || proc_way !== '0 || proc_busrdx !== 1'b0) begin
         errors++; $display("FAIL midreset_clear got pd=%b sd=%b way=%0d rdx=%b want 0 0 0 0",
                            proc_done, snp_done, proc_way, proc_busrdx);
      end
      idle();
      clear_model();
      repeat (2) @(posedge clk);
      #1 rst = 0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (proc_done !== 1'b0 || snp_done !== 1'b0) begin
            errors++; $display("FAIL midreset_nodone[%0d] got pd=%b sd=%b want 0 0", i, proc_done, snp_done);
         end
      end
      for (int s = 0; s < SETS; s++) begin
         idle();
         proc_valid = 1; proc_rd = 1; proc_index = IDX_W'(s);
         tick();
         checks++;
         if (proc_done !== 1'b1 || proc_way !== 3'd0) begin
            errors++; $display("FAIL midreset_victim[set %0d] got done=%b way=%0d want 1 0",
                               s, proc_done, proc_way);
         end
      end
      idle();
   endtask

   initial begin
      idle();
      clear_model();
      test_reset();
      test_miss_fill();
      test_hit_write();
      test_collision();
      test_snoop_cmds();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
